ymem_capture: RTL and testbench

Result-capture memory at the output end of the alignment accelerator, the receiving counterpart of the input image feeder. It accepts score/result words from the systolic array over a valid/ready handshake and writes them to sequential addresses of an internal 1K x 24 memory. It tracks how many words have arrived and signals completion after a programmed word count. The testbench or host reads the results back through a registered read port.

---
 rtl/ymem_capture.sv | 143 ++++++++++++++
 tb/tb_ymem_capture.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ymem_capture.sv
//==============================================================================
// Module      : ymem_capture
// Description : Result-capture memory for the alignment accelerator. It accepts
//               words over a valid/ready handshake, stores them at sequential
//               addresses of a DEPTH x DW memory, counts them against a
//               programmed length and flags completion. A registered read port
//               gives host access to the stored results.
//               Optional feature macro: YMEM_WRAP_EN (pointer wraps and
//               overwrites instead of stalling at DEPTH words).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ymem_capture #(
    parameter int DW    = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   len,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [15:0]   count,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          overflow,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [15:0]   r_count;
    logic [15:0]   r_len;
    logic          r_busy;
    logic          r_done;
    logic          r_overflow;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_full;
    logic          w_room;
    logic          w_ovf_evt;
    logic          w_ready;
    logic          w_accept;

`ifdef YMEM_WRAP_EN
    // Wrapping pointer: there is always room, the memory never reports full.
    assign w_full    = 1'b0;
    assign w_room    = 1'b1;
    assign w_ovf_evt = 1'b0;
`else
    // Stalling build: capture stops once DEPTH words have been stored and any
    // further offered word while stalled is an error.
    assign w_full    = ({1'b0, r_count} >= 17'(DEPTH));
    assign w_room    = !w_full;
    assign w_ovf_evt = in_valid && (r_state == S_CAPTURE) && w_full && !start;
`endif

    // A start in the same cycle takes priority, so the offered word is dropped.
    assign w_ready  = (r_state == S_CAPTURE) && !start && (r_count != r_len) && w_room;
    assign w_accept = in_valid && w_ready;

    // Capture control: state, write pointer, word count and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_len      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (start) begin
            r_state    <= S_CAPTURE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_len      <= len;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    if (w_accept) begin
                        r_ptr   <= r_ptr + AW'(1);
                        r_count <= r_count + 16'd1;
                    end
                    // Count reached the target on an earlier edge; complete now.
                    if (r_count == r_len) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    if (w_ovf_evt) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Storage array: written on handshake, never cleared.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_ptr] <= in_data;
        end
    end

    // Registered read port; reading on a write cycle returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign in_ready = w_ready;
    assign count    = r_count;
    assign busy     = r_busy;
    assign done     = r_done;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_ymem_capture.sv
//==============================================================================
// Module      : tb_ymem_capture
// Description : Self-checking bench for ymem_capture. Expected read data is
//               pushed to a queue when a read is issued and popped when the
//               registered read data appears.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ymem_capture;

    localparam int DW    = 24;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [15:0]   count;
    logic          busy;
    logic          done;
    logic          full;
    logic          overflow;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int            errors;
    int            checks;
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_d;

    ymem_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .overflow (overflow),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read and record what it must return.
    task automatic issue_read(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        sb.push_back(mm[a]);
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        len   = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        checks++;
        if ({in_ready, busy, done, full, overflow} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {in_ready, busy, done, full, overflow});
        end
        checks++;
        if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pulse_start(4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(24'hA00001 + i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d]: got %b want 1", i, in_ready); end
            mm[i] = in_data;
            tick();
            checks++;
            if (count !== 16'(i + 1)) begin errors++; $display("FAIL basic_count[%0d]: got %0d want %0d", i, count, i + 1); end
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early[%0d]: got %b want 0", i, done); end
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_end: got %b want 0", in_ready); end
        tick();
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL basic_done: got done,busy=%b want 10", {done, busy}); end
        for (int i = 0; i < 4; i++) begin
            issue_read(i);
            tick();
            exp_d = sb.pop_front();
            checks++;
            if (rd_data !== exp_d) begin errors++; $display("FAIL basic_rd[%0d]: got %h want %h", i, rd_data, exp_d); end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_data !== mm[3]) begin errors++; $display("FAIL rd_hold: got %h want %h", rd_data, mm[3]); end
    endtask

    task automatic test_gaps();
        int exp_cnt;
        int wa;
        exp_cnt = 0;
        wa = 0;
        pulse_start(3);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = DW'(24'hB00000 + k);
            if (k == 2) issue_read(1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL gaps_ready[%0d]: got %b want 1", k, in_ready); end
            if (in_valid) begin mm[wa] = in_data; wa++; exp_cnt++; end
            tick();
            checks++;
            if (count !== 16'(exp_cnt)) begin errors++; $display("FAIL gaps_count[%0d]: got %0d want %0d", k, count, exp_cnt); end
            if (k == 2) begin
                exp_d = sb.pop_front();
                checks++;
                if (rd_data !== exp_d) begin errors++; $display("FAIL gaps_rbw: got %h want %h", rd_data, exp_d); end
                rd_en = 1'b0;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b want 1", done); end
        for (int i = 0; i < 4; i++) begin
            issue_read(i);
            tick();
            exp_d = sb.pop_front();
            checks++;
            if (rd_data !== exp_d) begin errors++; $display("FAIL gaps_rd[%0d]: got %h want %h", i, rd_data, exp_d); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_len0();
        in_valid = 1'b1;
        in_data  = 24'hBADBAD;
        pulse_start(0);
        #1;
        checks++;
        if ({busy, in_ready, done} !== 3'b100) begin
            errors++; $display("FAIL len0_capture: got busy,ready,done=%b want 100", {busy, in_ready, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin errors++; $display("FAIL len0_done: got busy,done=%b want 01", {busy, done}); end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_read(i);
            tick();
            exp_d = sb.pop_front();
            checks++;
            if (rd_data !== exp_d) begin errors++; $display("FAIL len0_rd[%0d]: got %h want %h", i, rd_data, exp_d); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_restart();
        pulse_start(8);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(24'hC00000 + i);
            mm[i]    = in_data;
            tick();
        end
        checks++;
        if (count !== 16'd5) begin errors++; $display("FAIL restart_pre_count: got %0d want 5", count); end
        start    = 1'b1;
        len      = 16'd2;
        in_data  = 24'hDEAD00;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL restart_ready: got %b want 0", in_ready); end
        tick();
        start = 1'b0;
        checks++;
        if ({count, busy, done} !== {16'd0, 2'b10}) begin
            errors++; $display("FAIL restart_clear: got count=%0d busy=%b done=%b want 0 1 0", count, busy, done);
        end
        for (int i = 0; i < 2; i++) begin
            in_data = DW'(24'hC10000 + i);
            mm[i]   = in_data;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 16'd2) begin errors++; $display("FAIL restart_count: got %0d want 2", count); end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
        for (int i = 0; i < 5; i++) begin
            issue_read(i);
            tick();
            exp_d = sb.pop_front();
            checks++;
            if (rd_data !== exp_d) begin errors++; $display("FAIL restart_rd[%0d]: got %h want %h", i, rd_data, exp_d); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_capacity();
        logic exp_rdy;
        int   nrd;
        pulse_start(1030);
        for (int k = 0; k < 1030; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(24'h100000 + k);
`ifdef YMEM_WRAP_EN
            exp_rdy = 1'b1;
`else
            exp_rdy = (k < DEPTH);
`endif
            #1;
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL cap_ready[%0d]: got %b want %b", k, in_ready, exp_rdy); end
            if (exp_rdy) mm[k % DEPTH] = in_data;
            tick();
        end
        in_valid = 1'b0;
`ifdef YMEM_WRAP_EN
        checks++;
        if ({count, full, overflow} !== {16'd1030, 2'b00}) begin
            errors++; $display("FAIL cap_wrap_state: got count=%0d full=%b ovf=%b want 1030 0 0", count, full, overflow);
        end
        tick();
        checks++;
        if ({done, busy, overflow} !== 3'b100) begin
            errors++; $display("FAIL cap_wrap_done: got done,busy,ovf=%b want 100", {done, busy, overflow});
        end
        nrd = 6;
`else
        checks++;
        if ({count, full, in_ready, overflow, done} !== {16'd1024, 4'b1010}) begin
            errors++; $display("FAIL cap_stall_state: got count=%0d full=%b ready=%b ovf=%b done=%b want 1024 1 0 1 0",
                               count, full, in_ready, overflow, done);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b01) begin errors++; $display("FAIL cap_stall_hold: got done,busy=%b want 01", {done, busy}); end
        nrd = 2;
`endif
        for (int i = 0; i < nrd; i++) begin
            issue_read(i);
            tick();
            exp_d = sb.pop_front();
            checks++;
            if (rd_data !== exp_d) begin errors++; $display("FAIL cap_rd[%0d]: got %h want %h", i, rd_data, exp_d); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_start(20);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(24'hE00000 + k);
            mm[k]    = in_data;
            tick();
        end
        checks++;
        if (count !== 16'd10) begin errors++; $display("FAIL rmid_pre_count: got %0d want 10", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({count, busy, done, in_ready, overflow, rd_data} !== {16'd0, 4'b0000, 1'b0, {DW{1'b0}}}) begin
            errors++; $display("FAIL rmid_async: got count=%0d busy=%b done=%b ready=%b ovf=%b rd=%h want all 0",
                               count, busy, done, in_ready, overflow, rd_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({count, busy, done, in_ready} !== {16'd0, 3'b000}) begin
            errors++; $display("FAIL rmid_idle: got count=%0d busy=%b done=%b ready=%b want 0 0 0 0", count, busy, done, in_ready);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue_read(i);
            tick();
            exp_d = sb.pop_front();
            checks++;
            if (rd_data !== exp_d) begin errors++; $display("FAIL rmid_rd[%0d]: got %h want %h", i, rd_data, exp_d); end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < DEPTH; i++) mm[i] = 'x;
        test_reset();
        test_basic();
        test_gaps();
        test_len0();
        test_restart();
        test_capacity();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
